// File: rtl/nios_pio_edge_in.sv
// Avalon-MM input port: synchronised input lines, per-bit edge capture with an
// interrupt mask, and a free-running timestamp latched on every detected edge.
module nios_pio_edge_in #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EDGE_TYPE   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TS_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_IRQMASK = 3'd1,
    REG_EDGECAP = 3'd2,
    REG_TS_LAST = 3'd3,
    REG_TS_NOW  = 3'd4
  } reg_addr_e;

  typedef enum logic {
    GUARD = 1'b0,
    RUN   = 1'b1
  } guard_state_e;

  localparam int unsigned GCW = $clog2(SYNC_STAGES + 1);

  reg_addr_e           addr;
  logic                wr_en;
  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    sync_val;
  logic [WIDTH-1:0]    prev_q;
  logic [WIDTH-1:0]    edge_raw;
  logic [WIDTH-1:0]    edge_det;
  logic [WIDTH-1:0]    irqmask_q;
  logic [WIDTH-1:0]    edgecap_q;
  logic [WIDTH-1:0]    edgecap_d;
  logic [WIDTH-1:0]    clr_mask;
  logic [TS_WIDTH-1:0] ts_now_q;
  logic [TS_WIDTH-1:0] ts_last_q;
  logic [31:0]         rd_d;
  guard_state_e        state_q;
  guard_state_e        state_d;
  logic [GCW-1:0]      guard_cnt_q;
  logic [GCW-1:0]      guard_cnt_d;

  assign addr     = reg_addr_e'(address);
  assign wr_en    = chipselect & write;
  assign sync_val = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_val;
    end
  end

  // Guard window: detection stays off until the synchroniser and prev have
  // both been refilled from the live pins, so lines held high give no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= GUARD;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      GUARD: begin
        if (guard_cnt_q == GCW'(SYNC_STAGES)) begin
          state_d = RUN;
        end else begin
          guard_cnt_d = guard_cnt_q + GCW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = sync_val & ~prev_q;
      1:       edge_raw = ~sync_val & prev_q;
      default: edge_raw = sync_val ^ prev_q;
    endcase
    edge_det = (state_q == RUN) ? edge_raw : '0;
  end

  // A fresh edge overrides a same-cycle W1C of that bit.
  always_comb begin
    clr_mask = '0;
    if (wr_en && (addr == REG_EDGECAP)) begin
      clr_mask = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
      ts_now_q  <= '0;
      ts_last_q <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_en && (addr == REG_IRQMASK)) begin
        irqmask_q <= writedata[WIDTH-1:0];
      end
      edgecap_q <= edgecap_d;
      ts_now_q  <= ts_now_q + TS_WIDTH'(1);
      if (|edge_det) begin
        ts_last_q <= ts_now_q;
      end
      irq <= |(edgecap_q & irqmask_q);
    end
  end

  always_comb begin
    rd_d = '0;
    case (addr)
      REG_DATA:    rd_d = 32'(sync_val);
      REG_IRQMASK: rd_d = 32'(irqmask_q);
      REG_EDGECAP: rd_d = 32'(edgecap_q);
      REG_TS_LAST: rd_d = 32'(ts_last_q);
      REG_TS_NOW:  rd_d = 32'(ts_now_q);
      default:     rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_d;
    end
  end

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_writedata;
      assign unused_writedata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_nios_pio_edge_in.sv
// Scoreboard bench: three port variants share bus and pins; a history-based
// reference model predicts readdata and irq for every cycle.
`timescale 1ns/1ps
module tb_nios_pio_edge_in;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd_dut [NI];
  logic        irq_dut [NI];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2), .TS_WIDTH(8)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_dut[0]),
    .in_port(in_port), .irq(irq_dut[0]));

  nios_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(3), .TS_WIDTH(8)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_dut[1]),
    .in_port(in_port), .irq(irq_dut[1]));

  nios_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2), .TS_WIDTH(8)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_dut[2]),
    .in_port(in_port), .irq(irq_dut[2]));

  function automatic int unsigned edge_type_of(input int i);
    case (i)
      1:       return 0;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned sync_of(input int i);
    return (i == 1) ? 3 : 2;
  endfunction

  typedef struct packed {
    logic [2:0]             addr;
    logic [NI-1:0][31:0]    rd;
    logic [NI-1:0]          irq;
  } exp_t;

  exp_t        exp_q [$];
  logic [7:0]  hist [$];
  int unsigned ncyc = 0;
  logic [7:0]  m_cap [NI];
  logic [7:0]  m_mask [NI];
  logic [7:0]  m_tsl [NI];
  logic [7:0]  m_now = '0;

  // Synchronised value after ncyc clocks: the pin sample taken s clocks earlier.
  function automatic logic [7:0] synced(input int unsigned s);
    if (ncyc < s) return 8'h00;
    return hist[ncyc - s];
  endfunction

  initial begin : model
    exp_t        e;
    logic [7:0]  cur, old, det, clr;
    for (int i = 0; i < NI; i++) begin
      m_cap[i] = '0; m_mask[i] = '0; m_tsl[i] = '0;
    end
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        hist.delete();
        exp_q.delete();
        ncyc  = 0;
        m_now = '0;
        for (int i = 0; i < NI; i++) begin
          m_cap[i] = '0; m_mask[i] = '0; m_tsl[i] = '0;
        end
      end else begin
        e = '0;
        e.addr = address;
        for (int i = 0; i < NI; i++) begin
          cur = synced(sync_of(i));
          old = synced(sync_of(i) + 1);
          det = '0;
          if (ncyc >= sync_of(i) + 1) begin
            case (edge_type_of(i))
              0:       det = cur & ~old;
              1:       det = ~cur & old;
              default: det = cur ^ old;
            endcase
          end
          case (address)
            3'd0:    e.rd[i] = {24'h0, cur};
            3'd1:    e.rd[i] = {24'h0, m_mask[i]};
            3'd2:    e.rd[i] = {24'h0, m_cap[i]};
            3'd3:    e.rd[i] = {24'h0, m_tsl[i]};
            3'd4:    e.rd[i] = {24'h0, m_now};
            default: e.rd[i] = 32'h0;
          endcase
          e.irq[i] = |(m_cap[i] & m_mask[i]);
          clr = (chipselect && write && address == 3'd2) ? writedata[7:0] : 8'h00;
          if (chipselect && write && address == 3'd1) m_mask[i] = writedata[7:0];
          m_cap[i] = (m_cap[i] & ~clr) | det;
          if (det != 8'h00) m_tsl[i] = m_now;
        end
        m_now = m_now + 8'd1;
        hist.push_back(in_port);
        ncyc++;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      // Empty queue means reset is (or was just) active: all outputs cleared.
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '0;
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (rd_dut[i] !== e.rd[i]) begin
          n_fail++;
          $display("FAIL readdata inst%0d addr=%0d t=%0t: got %h expected %h",
                   i, e.addr, $time, rd_dut[i], e.rd[i]);
        end
        n_checks++;
        if (irq_dut[i] !== e.irq[i]) begin
          n_fail++;
          $display("FAIL irq inst%0d t=%0t: got %b expected %b", i, $time, irq_dut[i], e.irq[i]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic cs);
    chipselect = cs;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  initial begin : stimulus
    tick(3);
    reset_n = 1'b1;
    address = 3'd0;
    tick(10);
    address = 3'd2;
    tick(3);

    in_port = 8'h00;
    tick(8);
    bus_write(3'd2, 32'hFF, 1'b1);
    bus_write(3'd1, 32'h01, 1'b1);
    address = 3'd2;
    in_port[0] = 1'b1;
    tick(7);
    bus_write(3'd2, 32'h01, 1'b1);
    address = 3'd2;
    tick(3);

    in_port[3] = 1'b1;
    tick(6);
    in_port[3] = 1'b0;
    tick(6);

    for (int d = 2; d <= 3; d++) begin
      in_port[2] = 1'b0;
      tick(8);
      bus_write(3'd2, 32'hFF, 1'b1);
      address = 3'd2;
      in_port[2] = 1'b1;
      tick(d);
      bus_write(3'd2, 32'h04, 1'b1);
      address = 3'd2;
      tick(6);
    end
    in_port[2] = 1'b0;
    tick(2);
    bus_write(3'd2, 32'h04, 1'b1);
    address = 3'd2;
    tick(6);

    address = 3'd3;
    in_port[0] = 1'b0;
    tick(300);
    in_port[0] = 1'b1;
    address = 3'd4;
    tick(280);
    address = 3'd3;
    tick(6);

    bus_write(3'd0, 32'hDEADBEEF, 1'b1);
    bus_write(3'd3, 32'hDEADBEEF, 1'b1);
    bus_write(3'd4, 32'hDEADBEEF, 1'b1);
    bus_write(3'd6, 32'hDEADBEEF, 1'b1);
    address = 3'd6;
    tick(2);
    bus_write(3'd1, 32'hFF, 1'b0);
    address = 3'd1;
    tick(2);

    bus_write(3'd1, 32'hFF, 1'b1);
    address = 3'd2;
    in_port = 8'hA5;
    tick(6);
    reset_n = 1'b0;
    tick(2);
    in_port = 8'h5A;
    tick(1);
    reset_n = 1'b1;
    tick(12);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom & $urandom);
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = ($urandom_range(0, 4) != 0);
        write      = 1'b1;
        writedata  = $urandom;
      end else begin
        chipselect = 1'b0;
        write      = 1'b0;
      end
      tick(1);
    end
    chipselect = 1'b0;
    write      = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
